adpll_cpu_slave: RTL and testbench

- CPU-bus responder for the ADPLL controller; terminates the valid/address/wdata/wstrb/rdata/ready bus driven by the CPU or the bench tasks.
- Holds ADPLL configuration registers and the enable bit, and drives them to the ADPLL core.
- Filters the core's raw channel_lock into a debounced lock status with a sticky lock-lost flag, readable over the bus.

---
 rtl/adpll_cpu_slave_pkg.sv | 54 +++++
 rtl/adpll_lock_filter.sv | 61 ++++++
 rtl/adpll_cpu_slave.sv | 161 ++++++++++++++++
 tb/tb_adpll_cpu_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_cpu_slave_pkg.sv
// Shared register map, field layout and FSM encodings for the ADPLL CPU-bus slave.
package adpll_cpu_slave_pkg;

   localparam int ADPLL_ADDR_W = 4;
   localparam int ADPLL_DATA_W = 32;

   localparam logic [ADPLL_ADDR_W-1:0] ADPLL_CTRL   = 4'd0;
   localparam logic [ADPLL_ADDR_W-1:0] ADPLL_FCW    = 4'd1;
   localparam logic [ADPLL_ADDR_W-1:0] ADPLL_GAIN   = 4'd2;
   localparam logic [ADPLL_ADDR_W-1:0] ADPLL_STATUS = 4'd3;

   localparam int GAIN_ALPHA_L_LSB = 0;
   localparam int GAIN_ALPHA_M_LSB = 4;
   localparam int GAIN_ALPHA_S_LSB = 8;
   localparam int GAIN_BETA_LSB    = 12;
   localparam int GAIN_W           = 15;

   localparam int STAT_LOCKED  = 0;
   localparam int STAT_LOST    = 1;
   localparam int STAT_CFG_ERR = 2;
   localparam int STAT_W       = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   // Packed so that a zero-extended cast gives the GAIN register read layout.
   typedef struct packed {
      logic [2:0] beta;
      logic [3:0] alpha_s;
      logic [3:0] alpha_m;
      logic [3:0] alpha_l;
   } gain_t;

   function automatic logic [STAT_W-1:0] pack_status(input logic locked,
                                                     input logic lost,
                                                     input logic cfg_err);
      logic [STAT_W-1:0] s;
      s               = '0;
      s[STAT_LOCKED]  = locked;
      s[STAT_LOST]    = lost;
      s[STAT_CFG_ERR] = cfg_err;
      return s;
   endfunction

   function automatic gain_t unpack_gain(input logic [GAIN_W-1:0] w);
      gain_t g;
      g.alpha_l = w[GAIN_ALPHA_L_LSB +: 4];
      g.alpha_m = w[GAIN_ALPHA_M_LSB +: 4];
      g.alpha_s = w[GAIN_ALPHA_S_LSB +: 4];
      g.beta    = w[GAIN_BETA_LSB +: 3];
      return g;
   endfunction

endpackage

// File: rtl/adpll_lock_filter.sv
// Debounces the raw channel_lock into a qualified lock flag plus a sticky
// lock-lost flag that the CPU clears by reading STATUS.
module adpll_lock_filter
   import adpll_cpu_slave_pkg::*;
#(
   parameter int LOCK_CNT_W  = 8,
   parameter int LOCK_CYCLES = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic channel_lock,
   input  logic rd_clr,
   output logic locked,
   output logic lost
);

   localparam logic [LOCK_CNT_W-1:0] CNT_MAX = LOCK_CNT_W'(LOCK_CYCLES);

   logic [LOCK_CNT_W-1:0] cnt_r;
   logic [LOCK_CNT_W-1:0] cnt_nxt_s;
   logic                  locked_r;
   logic                  locked_nxt_s;
   logic                  lost_r;
   logic                  lost_set_s;

   // Saturating qualification counter; any lock dropout or disable restarts it.
   always_comb begin
      cnt_nxt_s = '0;
      if (en && channel_lock) begin
         if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_r + LOCK_CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = '0;
      end
   end

   assign locked_nxt_s = (cnt_nxt_s == CNT_MAX);
   // A disable also drops lock, but that is intentional and must not flag loss.
   assign lost_set_s   = locked_r && !locked_nxt_s && en;

   // Counter, lock and sticky loss state; a coinciding set beats the read-clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r    <= '0;
         locked_r <= 1'b0;
         lost_r   <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         locked_r <= locked_nxt_s;
         lost_r   <= lost_set_s || (lost_r && !rd_clr);
      end
   end

   assign locked = locked_r;
   assign lost   = lost_r;

endmodule

// File: rtl/adpll_cpu_slave.sv
// CPU-bus register slave for the ADPLL: configuration registers, enable,
// write protection while running, and the filtered lock status.
module adpll_cpu_slave
   import adpll_cpu_slave_pkg::*;
#(
   parameter int          ADDR_W      = ADPLL_ADDR_W,
   parameter int          DATA_W      = ADPLL_DATA_W,
   parameter int          LOCK_CNT_W  = 8,
   parameter int          LOCK_CYCLES = 100,
   parameter logic [25:0] FCW_RST     = 26'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wstrb,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   input  logic              channel_lock,
   output logic              en,
   output logic [25:0]       fcw,
   output logic [3:0]        alpha_l,
   output logic [3:0]        alpha_m,
   output logic [3:0]        alpha_s,
   output logic [2:0]        beta
);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADPLL_CTRL);
   localparam logic [ADDR_W-1:0] A_FCW    = ADDR_W'(ADPLL_FCW);
   localparam logic [ADDR_W-1:0] A_GAIN   = ADDR_W'(ADPLL_GAIN);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADPLL_STATUS);

   logic [0:0]        state_r;
   logic [0:0]        state_nxt_s;
   logic              ready_r;
   logic [DATA_W-1:0] rdata_r;
   logic [DATA_W-1:0] rdata_nxt_s;
   logic              en_r;
   logic [25:0]       fcw_r;
   gain_t             gain_r;
   logic              cfg_err_r;
   logic              accept_s;
   logic              wr_s;
   logic              status_rd_s;
   logic              cfg_set_s;
   logic              locked_s;
   logic              lost_s;
   logic              unused_wdata_s;

   // Only IDLE accepts, so a valid still held in the ACK cycle is not re-taken.
   assign accept_s    = valid && (state_r == ST_IDLE);
   assign wr_s        = accept_s && wstrb;
   assign status_rd_s = accept_s && !wstrb && (address == A_STATUS);
   assign cfg_set_s   = wr_s && en_r && ((address == A_FCW) || (address == A_GAIN));

   // Two-state handshake sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (valid) begin
               state_nxt_s = ST_ACK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACK:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Read mux, evaluated against pre-edge register values.
   always_comb begin
      rdata_nxt_s = '0;
      case (address)
         A_CTRL:   rdata_nxt_s = DATA_W'(en_r);
         A_FCW:    rdata_nxt_s = DATA_W'(fcw_r);
         A_GAIN:   rdata_nxt_s = DATA_W'(gain_r);
         A_STATUS: rdata_nxt_s = DATA_W'(pack_status(locked_s, lost_s, cfg_err_r));
         default:  rdata_nxt_s = '0;
      endcase
   end

   // Handshake state, ready pulse and read data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b0;
         rdata_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == ST_ACK);
         if (accept_s) begin
            rdata_r <= rdata_nxt_s;
         end else begin
            rdata_r <= '0;
         end
      end
   end

   // Configuration registers; FCW and GAIN are frozen while the loop runs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_r   <= 1'b0;
         fcw_r  <= FCW_RST;
         gain_r <= '0;
      end else if (wr_s) begin
         case (address)
            A_CTRL: en_r <= wdata[0];
            A_FCW: begin
               if (!en_r) begin
                  fcw_r <= wdata[25:0];
               end
            end
            A_GAIN: begin
               if (!en_r) begin
                  gain_r <= unpack_gain(wdata[GAIN_W-1:0]);
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky configuration-error flag, cleared by a STATUS read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_err_r <= 1'b0;
      end else if (cfg_set_s) begin
         cfg_err_r <= 1'b1;
      end else if (status_rd_s) begin
         cfg_err_r <= 1'b0;
      end
   end

   adpll_lock_filter #(
      .LOCK_CNT_W  (LOCK_CNT_W),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock_filter (
      .clk          (clk),
      .rst          (rst),
      .en           (en_r),
      .channel_lock (channel_lock),
      .rd_clr       (status_rd_s),
      .locked       (locked_s),
      .lost         (lost_s)
   );

   assign unused_wdata_s = ^wdata[DATA_W-1:26];

   assign rdata   = rdata_r;
   assign ready   = ready_r;
   assign en      = en_r;
   assign fcw     = fcw_r;
   assign alpha_l = gain_r.alpha_l;
   assign alpha_m = gain_r.alpha_m;
   assign alpha_s = gain_r.alpha_s;
   assign beta    = gain_r.beta;

endmodule

// File: tb/tb_adpll_cpu_slave.sv
// Directed bench for adpll_cpu_slave: register access, write protection,
// lock qualification boundary, lost flag semantics and mid-transaction reset.
module tb_adpll_cpu_slave;

   localparam logic [3:0] A_CTRL   = 4'd0;
   localparam logic [3:0] A_FCW    = 4'd1;
   localparam logic [3:0] A_GAIN   = 4'd2;
   localparam logic [3:0] A_STATUS = 4'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [3:0]  address;
   logic [31:0] wdata;
   logic        wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic        channel_lock;
   logic        en;
   logic [25:0] fcw;
   logic [3:0]  alpha_l;
   logic [3:0]  alpha_m;
   logic [3:0]  alpha_s;
   logic [2:0]  beta;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adpll_cpu_slave dut (
      .clk          (clk),
      .rst          (rst),
      .valid        (valid),
      .address      (address),
      .wdata        (wdata),
      .wstrb        (wstrb),
      .rdata        (rdata),
      .ready        (ready),
      .channel_lock (channel_lock),
      .en           (en),
      .fcw          (fcw),
      .alpha_l      (alpha_l),
      .alpha_m      (alpha_m),
      .alpha_s      (alpha_s),
      .beta         (beta)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge; returns 1 ns after the edge following the ready cycle.
   task automatic bus_xfer(input logic [3:0] a, input logic [31:0] d, input logic w,
                           output logic [31:0] rd);
      int cyc;
      cyc     = 0;
      rd      = 32'h0;
      valid   = 1'b1;
      address = a;
      wdata   = d;
      wstrb   = w;
      while (cyc < 4) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ready) break;
      end
      check_val("ready_latency", 32'(cyc), 32'd1);
      rd = rdata;
      @(negedge clk);
      valid = 1'b0;
      wstrb = 1'b0;
      @(posedge clk);
      #1;
      check_val("ready_one_cycle", {31'h0, ready}, 32'h0);
      check_val("rdata_idle_zero", rdata, 32'h0);
   endtask

   task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] rd;
      @(negedge clk);
      bus_xfer(a, d, 1'b1, rd);
   endtask

   task automatic reg_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      @(negedge clk);
      bus_xfer(a, 32'h0, 1'b0, rd);
      check_val(tag, rd, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      rst          = 1'b0;
      valid        = 1'b0;
      address      = 4'd0;
      wdata        = 32'h0;
      wstrb        = 1'b0;
      channel_lock = 1'b0;
      #12;
      check_val("rst_ready", {31'h0, ready}, 32'h0);
      check_val("rst_rdata", rdata, 32'h0);
      check_val("rst_en", {31'h0, en}, 32'h0);
      check_val("rst_fcw", {6'h0, fcw}, 32'h0);
      check_val("rst_gain", {17'h0, beta, alpha_s, alpha_m, alpha_l}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) begin
         reg_rd("rst_read", 4'(i), 32'h0);
      end

      // Configuration with the loop disabled.
      reg_wr(A_FCW, 32'h01A2B3C4);
      reg_wr(A_GAIN, 32'h00005321);
      reg_rd("fcw_readback", A_FCW, 32'h01A2B3C4);
      reg_rd("gain_readback", A_GAIN, 32'h00005321);
      check_val("fcw_out", {6'h0, fcw}, 32'h01A2B3C4);
      check_val("alpha_l", {28'h0, alpha_l}, 32'd1);
      check_val("alpha_m", {28'h0, alpha_m}, 32'd2);
      check_val("alpha_s", {28'h0, alpha_s}, 32'd3);
      check_val("beta", {29'h0, beta}, 32'd5);

      // Unmapped address.
      reg_wr(4'd9, 32'hFFFFFFFF);
      reg_rd("unmapped_read", 4'd9, 32'h0);
      reg_rd("fcw_after_unmapped", A_FCW, 32'h01A2B3C4);

      // Write protection while enabled.
      reg_wr(A_CTRL, 32'h1);
      check_val("en_out", {31'h0, en}, 32'h1);
      reg_rd("ctrl_readback", A_CTRL, 32'h1);
      reg_wr(A_FCW, 32'h00000001);
      reg_wr(A_GAIN, 32'h00000000);
      check_val("fcw_protected", {6'h0, fcw}, 32'h01A2B3C4);
      check_val("gain_protected", {17'h0, beta, alpha_s, alpha_m, alpha_l}, 32'h00005321);
      reg_rd("status_cfg_err", A_STATUS, 32'h4);
      reg_rd("status_cfg_clr", A_STATUS, 32'h0);

      // Lock boundary: sampled after 99 qualifying edges -> not locked.
      @(negedge clk);
      channel_lock = 1'b1;
      repeat (99) @(posedge clk);
      @(negedge clk);
      channel_lock = 1'b0;
      bus_xfer(A_STATUS, 32'h0, 1'b0, rd);
      check_val("lock_at_99", rd, 32'h0);
      // Sampled after exactly 100 qualifying edges -> locked.
      @(negedge clk);
      channel_lock = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      bus_xfer(A_STATUS, 32'h0, 1'b0, rd);
      check_val("lock_at_100", rd, 32'h1);

      // One-cycle dropout sets lost.
      @(negedge clk);
      channel_lock = 1'b0;
      @(negedge clk);
      channel_lock = 1'b1;
      bus_xfer(A_STATUS, 32'h0, 1'b0, rd);
      check_val("lost_set", rd, 32'h2);
      repeat (100) @(posedge clk);
      reg_rd("relock_lost_clr", A_STATUS, 32'h1);

      // Dropout coinciding with the clearing read: set wins.
      @(negedge clk);
      channel_lock = 1'b0;
      bus_xfer(A_STATUS, 32'h0, 1'b0, rd);
      check_val("coincide_sample", rd, 32'h1);
      reg_rd("coincide_set_wins", A_STATUS, 32'h2);
      reg_rd("coincide_cleared", A_STATUS, 32'h0);

      // Disabling while locked clears lock without flagging loss.
      @(negedge clk);
      channel_lock = 1'b1;
      repeat (105) @(posedge clk);
      reg_rd("locked_before_dis", A_STATUS, 32'h1);
      reg_wr(A_CTRL, 32'h0);
      check_val("en_cleared", {31'h0, en}, 32'h0);
      reg_rd("disable_no_lost", A_STATUS, 32'h0);

      // Reset in the ACK cycle aborts the transaction.
      reg_wr(A_CTRL, 32'h1);
      @(negedge clk);
      valid   = 1'b1;
      address = A_FCW;
      wstrb   = 1'b0;
      @(posedge clk);
      #1;
      check_val("ack_before_rst", {31'h0, ready}, 32'h1);
      #1;
      rst = 1'b0;
      #1;
      check_val("abort_ready", {31'h0, ready}, 32'h0);
      check_val("abort_rdata", rdata, 32'h0);
      check_val("abort_en", {31'h0, en}, 32'h0);
      check_val("abort_fcw", {6'h0, fcw}, 32'h0);
      check_val("abort_gain", {17'h0, beta, alpha_s, alpha_m, alpha_l}, 32'h0);
      @(negedge clk);
      valid = 1'b0;
      @(posedge clk);
      #1;
      check_val("abort_no_ready", {31'h0, ready}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      reg_rd("post_rst_fcw", A_FCW, 32'h0);
      reg_rd("post_rst_status", A_STATUS, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
